// File: rtl/down_count_monitor_pkg.sv
// Shared types and constants for the down-counter monitor: FSM states, step
// classes and the hex 7-segment table.
package down_count_monitor_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPrime = 2'd1,
    StTrack = 2'd2,
    StError = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    StepHold = 2'd0,
    StepStep = 2'd1,
    StepWrap = 2'd2,
    StepBad  = 2'd3
  } step_e;

  // {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SegTable [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // 0 -> F is checked before the decrement so it is never classed as a plain step.
  function automatic step_e classify(logic [3:0] prev, logic [3:0] cur);
    logic [3:0] dec;
    dec = prev - 4'd1;
    if (cur == prev) begin
      return StepHold;
    end else if (prev == 4'd0 && cur == 4'hF) begin
      return StepWrap;
    end else if (cur == dec) begin
      return StepStep;
    end else begin
      return StepBad;
    end
  endfunction

endpackage

// File: rtl/down_count_monitor_if.sv
// Counter sample inputs and monitor results. master = counter/board side,
// slave = the monitor.
interface down_count_monitor_if #(
  parameter int unsigned WRAP_W = 8
);
  logic              QA;
  logic              QB;
  logic              QC;
  logic              QD;
  logic              clr_err;
  logic [6:0]        seg;
  logic              tc_pulse;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              step_err;
  logic              valid;

  modport master (
    output QA, QB, QC, QD, clr_err,
    input  seg, tc_pulse, wrap_pulse, wrap_cnt, step_err, valid
  );

  modport slave (
    input  QA, QB, QC, QD, clr_err,
    output seg, tc_pulse, wrap_pulse, wrap_cnt, step_err, valid
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to 7-segment decoder, optionally inverted for
// common-anode displays.
module hex_to_seg7
  import down_count_monitor_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SegTable[hex_i] ^ {7{ACTIVE_LOW}};

endmodule

// File: rtl/down_count_monitor.sv
// Samples a 4-bit down counter, checks each change is a legal decrement, and
// produces terminal-count/wrap pulses, a saturating wrap count and a 7-seg code.
module down_count_monitor
  import down_count_monitor_pkg::*;
#(
  parameter int unsigned WRAP_W         = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  down_count_monitor_if.slave  bus_io
);

  state_e            state_q, state_d;
  step_e             step_cls;
  logic [3:0]        cur_q, prev_q;
  logic [6:0]        seg_q, seg_d, seg_dec;
  logic              tc_q, tc_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  localparam logic [6:0]        SegReset = {7{SEG_ACTIVE_LOW}};
  localparam logic [WRAP_W-1:0] CntOne   = {{(WRAP_W-1){1'b0}}, 1'b1};

  hex_to_seg7 #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_hex_to_seg7 (
    .hex_i (cur_q),
    .seg_o (seg_dec)
  );

  assign step_cls = classify(prev_q, cur_q);

  always_comb begin
    state_d    = state_q;
    tc_d       = 1'b0;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    valid_d    = valid_q;
    seg_d      = (state_q == StIdle) ? seg_q : seg_dec;
    unique case (state_q)
      StIdle: begin
        state_d = StPrime;
        valid_d = 1'b0;
      end
      StPrime: begin
        state_d = StTrack;
        valid_d = 1'b1;
      end
      StTrack: begin
        unique case (step_cls)
          StepStep: tc_d = (cur_q == 4'd0);
          StepWrap: begin
            wrap_d = 1'b1;
            if (wrap_cnt_q != '1) wrap_cnt_d = wrap_cnt_q + CntOne;
          end
          StepBad: begin
            state_d = StError;
            valid_d = 1'b0;
          end
          default: ;
        endcase
      end
      StError: begin
        valid_d = 1'b0;
        if (bus_io.clr_err) state_d = StPrime;
      end
      default: state_d = StIdle;
    endcase
    err_d = (state_d == StError);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cur_q      <= 4'd0;
      prev_q     <= 4'd0;
      seg_q      <= SegReset;
      tc_q       <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= {bus_io.QD, bus_io.QC, bus_io.QB, bus_io.QA};
      prev_q     <= cur_q;
      seg_q      <= seg_d;
      tc_q       <= tc_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign bus_io.seg        = seg_q;
  assign bus_io.tc_pulse   = tc_q;
  assign bus_io.wrap_pulse = wrap_q;
  assign bus_io.wrap_cnt   = wrap_cnt_q;
  assign bus_io.step_err   = err_q;
  assign bus_io.valid      = valid_q;

endmodule

// File: doc/down_count_monitor.md
Name: down_count_monitor

Overview:
Consumer stage placed directly downstream of the 4-bit T-flip-flop down counter. It samples the counter outputs QA..QD and checks that each change is a legal single-step decrement. It emits a terminal-count pulse and a wrap (underflow) pulse, keeps a saturating wrap count, and drives a registered hex 7-segment code of the current value. It is the counter's observation and display front-end on the board.

Parameters:
WRAP_W, 8, width of the saturating wrap-event counter (legal range 2..16)
SEG_ACTIVE_LOW, 0, 1 = invert all segment outputs for common-anode displays

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
QA  input  1  counter bit 0 (LSB)
QB  input  1  counter bit 1
QC  input  1  counter bit 2
QD  input  1  counter bit 3 (MSB)
clr_err  input  1  synchronous clear of the error state; level-sensitive
seg  output  7  {g,f,e,d,c,b,a} segment code of the last sampled value
tc_pulse  output  1  one-cycle pulse on a legal step into value 0
wrap_pulse  output  1  one-cycle pulse on a legal step 0 -> F
wrap_cnt  output  WRAP_W  saturating count of wrap events
step_err  output  1  high while in ERROR
valid  output  1  high once a first sample has been taken and no error is present

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; cur=0, prev=0.
  - All outputs 0.
  - seg=7'h00 (7'h7F when SEG_ACTIVE_LOW=1).
- Input stage: cur <= {QD,QC,QB,QA} every clock. prev <= cur every clock.
- Comparison uses cur against prev.
  - Outputs register on the same edge that loads prev.
  - Result: latency is 2 clocks from an input change to the pulse or seg update.
- Step classes, evaluated combinationally on (prev, cur):
  - HOLD: cur == prev
  - STEP: cur == prev-1 mod 16 and prev != 0
  - WRAP: prev == 0 and cur == 4'hF
  - BAD: anything else
- State machine:
  - IDLE: first clock after reset, no comparison. Go to PRIME.
  - PRIME: prev is now valid. Set valid=1 and go to TRACK. No pulses are issued.
  - TRACK:
    - HOLD: no pulse.
    - STEP: tc_pulse=1 when cur==0.
    - WRAP: wrap_pulse=1 and wrap_cnt increments, saturating at all-ones.
    - BAD: go to ERROR; step_err=1, valid=0, no pulses.
  - ERROR:
    - Pulses are suppressed and wrap_cnt is frozen. seg keeps tracking cur.
    - clr_err=1 returns the machine to PRIME, so the next cycle re-primes without judging the first post-error pair.
    - wrap_cnt is preserved.
- tc_pulse and wrap_pulse are never both high.
  - A step 1->0 gives tc_pulse only.
  - A step 0->F gives wrap_pulse only.
- A counter that sits in HOLD indefinitely is legal and produces no output activity.
- seg is updated every clock from cur, in every state except IDLE.
  - Encoding: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.
  - The code is XOR-inverted when SEG_ACTIVE_LOW=1.
- Reset mid-operation: all state and outputs clear immediately on the falling edge of rst, including wrap_cnt. The pulses deassert asynchronously.
- clr_err asserted outside ERROR has no effect.
- Simultaneous BAD and clr_err in TRACK: BAD wins, so the machine enters ERROR.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE=2'd0, PRIME=2'd1, TRACK=2'd2, ERROR=2'd3
  - the 16-entry segment constant table
  - the step-class encodings
- One sub-module: hex_to_seg7. It is a pure combinational 4-bit to 7-bit decoder with an active-low parameter.
- Registers and the FSM live in down_count_monitor.

Test Plan:
- Reset applied, then released with QA..QD=F.
  - Required: all outputs 0 during reset.
  - Required: valid=1 two clocks after release.
  - Required: seg=71 on the following cycle.
- Legal sequence F,E,...,1,0,F, each value held 3 clocks.
  - Required: exactly one tc_pulse, 2 clocks after 0 appears.
  - Required: exactly one wrap_pulse on the F step.
  - Required: wrap_cnt=1 and step_err=0.
- Counter jumps 9 -> 6.
  - Required: step_err=1 and valid=0 two clocks later.
  - Then apply 5 -> 4: no pulses and wrap_cnt unchanged.
  - Then pulse clr_err: valid=1 again after the PRIME cycle.
- WRAP_W=2, drive 5 full down cycles.
  - Required: wrap_cnt saturates at 3 and wrap_pulse still fires 5 times.
- rst asserted mid-cycle while wrap_pulse is high.
  - Required: wrap_pulse, wrap_cnt and seg clear at once, without waiting for clk.
- SEG_ACTIVE_LOW=1 with input 8.
  - Required: seg=00, and seg=7F during reset.
